accum_stream_adder: RTL and testbench

- Sequential accumulator directly downstream of the 32-bit ripple/CLA adder datapath.
- Accepts a burst of `len` signed/unsigned operands over a valid/ready stream and adds each one into a running sum.
- Reports the final sum with sticky carry-out and sticky signed-overflow flags over a valid/ready output.
- Feeds the result/flag bus of the ALU writeback path.

---
 rtl/accum_stream_if.sv | 28 ++
 rtl/accum_stream_adder.sv | 169 ++++++++++++++++
 tb/tb_accum_stream_adder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/accum_stream_if.sv
// Valid/ready stream bundle between an operand producer and the accumulator:
// burst control, operand input, and result/flag output.
interface accum_stream_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_co;
  logic             out_of;
  logic             busy;

  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_co, out_of, busy
  );

  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_co, out_of, busy
  );
endinterface

// File: rtl/accum_stream_adder.sv
// Burst accumulator: adds len operands into a modulo-2^WIDTH running sum,
// tracking sticky carry-out and signed-overflow flags, then hands off the result.
module accum_stream_adder #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  accum_stream_if.slave  s
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;

  logic [WIDTH-1:0] acc_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] len_q_r;
  logic             co_r;
  logic             of_r;

  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             in_ready_s;
  logic             out_valid_s;
  logic             busy_s;

  logic             beat_s;
  logic             last_s;
  logic             start_ok_s;
  logic [CNT_W-1:0] count_inc_s;
  logic [WIDTH:0]   sum_ext_s;

  // Two's-complement overflow: like-signed operands giving an opposite-signed result.
  function automatic logic add_overflow(input logic a_msb, input logic b_msb,
                                        input logic s_msb);
    return (a_msb & b_msb & ~s_msb) | (~a_msb & ~b_msb & s_msb);
  endfunction

  assign beat_s      = s.in_valid & in_ready_r;
  assign start_ok_s  = (state_r == IDLE) & s.start;
  assign count_inc_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
  assign last_s      = (count_inc_s == len_q_r);
  assign sum_ext_s   = {1'b0, acc_r} + {1'b0, s.in_data};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (s.start) begin
          state_next_s = (s.len == {CNT_W{1'b0}}) ? DONE : ACCUM;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCUM: begin
        if (beat_s && last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = ACCUM;
        end
      end
      DONE: begin
        if (out_valid_r && s.out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the handshake outputs come straight from flops.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    busy_s      = 1'b0;
    case (state_next_s)
      IDLE: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        busy_s      = 1'b0;
      end
      ACCUM: begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
        busy_s      = 1'b1;
      end
      DONE: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b1;
        busy_s      = 1'b1;
      end
      default: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        busy_s      = 1'b0;
      end
    endcase
  end

  // Handshake/status output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      busy_r      <= busy_s;
    end
  end

  // Accumulator and sticky flags; they double as the held result outside a burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r   <= {WIDTH{1'b0}};
      count_r <= {CNT_W{1'b0}};
      len_q_r <= {CNT_W{1'b0}};
      co_r    <= 1'b0;
      of_r    <= 1'b0;
    end else if (start_ok_s) begin
      acc_r   <= {WIDTH{1'b0}};
      count_r <= {CNT_W{1'b0}};
      len_q_r <= s.len;
      co_r    <= 1'b0;
      of_r    <= 1'b0;
    end else if (beat_s) begin
      acc_r   <= sum_ext_s[WIDTH-1:0];
      count_r <= count_inc_s;
      len_q_r <= len_q_r;
      co_r    <= co_r | sum_ext_s[WIDTH];
      of_r    <= of_r | add_overflow(acc_r[WIDTH-1], s.in_data[WIDTH-1],
                                     sum_ext_s[WIDTH-1]);
    end else begin
      acc_r   <= acc_r;
      count_r <= count_r;
      len_q_r <= len_q_r;
      co_r    <= co_r;
      of_r    <= of_r;
    end
  end

  assign s.in_ready  = in_ready_r;
  assign s.out_valid = out_valid_r;
  assign s.busy      = busy_r;
  assign s.out_sum   = acc_r;
  assign s.out_co    = co_r;
  assign s.out_of    = of_r;

endmodule

// File: tb/tb_accum_stream_adder.sv
// Directed self-checking bench for accum_stream_adder with hand-computed results.
module tb_accum_stream_adder;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  accum_stream_if #(.WIDTH(32), .CNT_W(8)) bus ();

  accum_stream_adder #(.WIDTH(32), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [7:0] l);
    bus.start = 1'b1;
    bus.len   = l;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input int gap);
    int n;
    bus.in_valid = 1'b0;
    bus.in_data  = 32'hDEADBEEF;
    repeat (gap) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [31:0] sum,
                              input logic co, input logic of);
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, "_sum"},   bus.out_sum, sum);
    chk({tag, "_co"},    {31'd0, bus.out_co}, {31'd0, co});
    chk({tag, "_of"},    {31'd0, bus.out_of}, {31'd0, of});
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_drain_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_drain_busy"},  {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.len       = 8'd0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'd0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_busy",      {31'd0, bus.busy},      32'd0);
    chk("rst_sum",       bus.out_sum,            32'd0);
    chk("rst_co",        {31'd0, bus.out_co},    32'd0);
    chk("rst_of",        {31'd0, bus.out_of},    32'd0);
    rst_n = 1'b1;
    tick();

    // Simple burst, back-to-back beats
    start_burst(8'd3);
    chk("t1_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("t1_busy",     {31'd0, bus.busy},     32'd1);
    send_beat(32'h1, 0);
    send_beat(32'h2, 0);
    chk("t1_not_yet", {31'd0, bus.out_valid}, 32'd0);
    send_beat(32'h3, 0);
    check_result("t1", 32'h6, 1'b0, 1'b0);
    chk("t1_in_ready_done", {31'd0, bus.in_ready}, 32'd0);
    drain("t1");

    // Positive signed overflow
    start_burst(8'd2);
    send_beat(32'h7FFFFFFF, 0);
    send_beat(32'h00000001, 0);
    check_result("t2", 32'h80000000, 1'b0, 1'b1);
    drain("t2");

    // Overflow stays sticky after the sum returns into range
    start_burst(8'd3);
    send_beat(32'h7FFFFFFF, 0);
    send_beat(32'h00000001, 0);
    send_beat(32'hFFFFFFFF, 0);
    check_result("t3", 32'h7FFFFFFF, 1'b1, 1'b1);
    drain("t3");

    // Negative overflow with carry
    start_burst(8'd2);
    send_beat(32'h80000000, 0);
    send_beat(32'h80000000, 0);
    check_result("t4", 32'h00000000, 1'b1, 1'b1);
    drain("t4");

    // Carry without signed overflow
    start_burst(8'd2);
    send_beat(32'hFFFFFFFF, 0);
    send_beat(32'hFFFFFFFF, 0);
    check_result("t5", 32'hFFFFFFFE, 1'b1, 1'b0);
    drain("t5");

    // Zero length: straight to DONE with a cleared result
    start_burst(8'd0);
    check_result("t6", 32'h0, 1'b0, 1'b0);
    chk("t6_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("t6_busy",     {31'd0, bus.busy},     32'd1);
    tick();
    chk("t6_in_ready2", {31'd0, bus.in_ready}, 32'd0);
    drain("t6");
    chk("t6_in_ready3", {31'd0, bus.in_ready}, 32'd0);

    // Gapped beats with a start pulse in ACCUM
    start_burst(8'd4);
    send_beat(32'h11111111, $urandom_range(0, 3));
    send_beat(32'h22222222, $urandom_range(0, 3));
    bus.start = 1'b1;
    bus.len   = 8'd1;
    tick();
    bus.start = 1'b0;
    chk("t7_accum_start_ignored", {31'd0, bus.in_ready}, 32'd1);
    send_beat(32'h33333333, $urandom_range(0, 3));
    chk("t7_not_yet", {31'd0, bus.out_valid}, 32'd0);
    send_beat(32'h44444444, $urandom_range(0, 3));
    check_result("t7", 32'hAAAAAAAA, 1'b0, 1'b1);

    // Backpressure with a start pulse in DONE
    for (int i = 0; i < 5; i++) begin
      bus.start = (i == 2);
      bus.len   = 8'd2;
      tick();
      chk("t7_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("t7_hold_sum",   bus.out_sum,            32'hAAAAAAAA);
    end
    bus.start     = 1'b1;
    bus.len       = 8'd3;
    bus.out_ready = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    chk("t7_hs_valid",    {31'd0, bus.out_valid}, 32'd0);
    chk("t7_hs_in_ready", {31'd0, bus.in_ready},  32'd0);
    tick();
    chk("t7_idle_busy",     {31'd0, bus.busy},     32'd0);
    chk("t7_idle_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("t7_idle_sum_held", bus.out_sum,           32'hAAAAAAAA);
    chk("t7_idle_of_held",  {31'd0, bus.out_of},   32'd1);

    // Reset mid-burst, then a fresh burst
    start_burst(8'd5);
    send_beat(32'h10, 0);
    send_beat(32'h20, 0);
    rst_n = 1'b0;
    #1;
    chk("t8_rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    chk("t8_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t8_rst_sum",       bus.out_sum,            32'd0);
    chk("t8_rst_busy",      {31'd0, bus.busy},      32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t8_idle_valid", {31'd0, bus.out_valid}, 32'd0);
    start_burst(8'd1);
    send_beat(32'h5, 0);
    check_result("t8", 32'h5, 1'b0, 1'b0);
    drain("t8");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
